aes256_uart_ctrl: RTL

Frame sequencer between the UART byte interfaces (`serial_rx` / `serial_tx`) and the AES-256 encryption core inside `aes256_uart`. It assembles a 48-byte request frame (32-byte key, then 16-byte plaintext) into the core's key and text inputs, then starts one encryption and waits for completion. It streams the 16 ciphertext bytes back out through the transmitter. It also recovers from truncated frames with an inter-byte timeout and reports overrun and status.

---
 rtl/aes256_uart_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/aes256_uart_ctrl.sv
// Frame sequencer between the UART byte streams and the AES-256 core: collects a
// 48-byte key+plaintext frame, runs one encryption, streams 16 ciphertext bytes back.
module aes256_uart_ctrl #(
  parameter int TIMEOUT_CYCLES = 3480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_new_data,
  output logic [7:0]   tx_data,
  output logic         tx_new_data,
  input  logic         tx_busy,
  output logic [255:0] aes_key,
  output logic [127:0] aes_text_in,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out,
  output logic         busy,
  output logic [7:0]   frame_count,
  output logic         timeout_err,
  output logic         overrun,
  output logic [2:0]   dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_FRAME = 3'd0,
    START    = 3'd1,
    WAIT_AES = 3'd2,
    TX_LOAD  = 3'd3,
    TX_GAP   = 3'd4
  } state_e;

  // Handshake: rx_new_data/aes_done/aes_start/tx_new_data are single-cycle strobes;
  // a byte is only sent while tx_busy is low, and tx_busy is ignored for one cycle after.
  state_e          state_q;
  logic [383:0]    frame_q;
  logic [5:0]      bidx_q;
  logic [127:0]    outbuf_q;
  logic [3:0]      tidx_q;
  logic [CW-1:0]   tcnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_new_data_q;
  logic            aes_start_q;
  logic            busy_q;
  logic [7:0]      frame_count_q;
  logic            timeout_err_q;
  logic            overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_FRAME;
      frame_q       <= '0;
      bidx_q        <= '0;
      tidx_q        <= '0;
      tcnt_q        <= '0;
      tx_data_q     <= '0;
      tx_new_data_q <= 1'b0;
      aes_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      tx_new_data_q <= 1'b0;
      aes_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      if (rx_new_data && state_q != RX_FRAME) overrun_q <= 1'b1;
      case (state_q)
        RX_FRAME: begin
          if (rx_new_data) begin
            frame_q[{bidx_q, 3'b000} +: 8] <= rx_data;
            tcnt_q <= '0;
            if (bidx_q == 6'd47) begin
              bidx_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= START;
            end else begin
              bidx_q <= bidx_q + 6'd1;
            end
          end else if (bidx_q != 6'd0) begin
            // Partial frame stalled: drop it, keep stale frame bytes.
            if (tcnt_q == TO_LAST) begin
              bidx_q        <= '0;
              tcnt_q        <= '0;
              timeout_err_q <= 1'b1;
            end else begin
              tcnt_q <= tcnt_q + CW'(1);
            end
          end else begin
            tcnt_q <= '0;
          end
        end
        START: begin
          aes_start_q <= 1'b1;
          state_q     <= WAIT_AES;
        end
        WAIT_AES: begin
          if (aes_done) begin
            tidx_q  <= '0;
            state_q <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data_q     <= outbuf_q[{tidx_q, 3'b000} +: 8];
            tx_new_data_q <= 1'b1;
            state_q       <= TX_GAP;
          end
        end
        TX_GAP: begin
          if (tidx_q == 4'd15) begin
            frame_count_q <= frame_count_q + 8'd1;
            busy_q        <= 1'b0;
            state_q       <= RX_FRAME;
          end else begin
            tidx_q  <= tidx_q + 4'd1;
            state_q <= TX_LOAD;
          end
        end
        default: state_q <= RX_FRAME;
      endcase
    end
  end

  // Ciphertext buffer survives reset on purpose.
  always_ff @(posedge clk) begin
    if (!rst && state_q == WAIT_AES && aes_done) outbuf_q <= aes_text_out;
  end

  assign aes_key     = frame_q[255:0];
  assign aes_text_in = frame_q[383:256];
  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_new_data_q;
  assign aes_start   = aes_start_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule
